// File: rtl/layer2_result_readout.sv
// layer2_result_readout: captures 128-bit layer-2 output pixels into a local
// buffer and serves them to the CPU over a 32-bit registered read port, with
// a status word (count / overflow / fill / done) and a write-to-clear command.
module layer2_result_readout #(
    parameter int unsigned ROW_NUM     = 28,
    parameter int unsigned COL_NUM     = 28,
    parameter logic [31:0] RESULT_BASE = 32'h0002_0000,
    parameter logic [31:0] STATUS_ADDR = 32'h0001_FFF0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         save_enable,
    input  logic [15:0]  save_row,
    input  logic [15:0]  save_col,
    input  logic [127:0] save_data,
    input  logic         calculation_done,
    input  logic [31:0]  araddr,
    input  logic         arvalid,
    input  logic [31:0]  awaddr,
    input  logic         awvalid,
    input  logic [31:0]  wdata,
    input  logic         wvalid,
    output logic [31:0]  rdata,
    output logic         result_ready,
    output logic [15:0]  save_count
);

    localparam int unsigned PIX_NUM    = ROW_NUM * COL_NUM;
    localparam int unsigned PIX_W      = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
    localparam logic [15:0] ROW_LIM    = 16'(ROW_NUM);
    localparam logic [15:0] COL_LIM    = 16'(COL_NUM);
    localparam logic [31:0] RESULT_END = RESULT_BASE + 32'(PIX_NUM * 16);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [31:0]  r_rdata;
    logic [15:0]  r_save_count;
    logic         r_overflow;

    // One 128-bit entry per pixel; word p of a pixel is entry bits [32p+31:32p],
    // which places ch[2p] in the low half as required.
    logic [127:0] r_buf [PIX_NUM];

    logic             w_clear;
    logic             w_in_range;
    logic             w_save_ok;
    logic             w_drop;
    logic [PIX_W-1:0] w_wr_pix;
    logic             w_in_win;
    logic             w_is_status;
    logic [31:0]      w_rd_off;
    logic [PIX_W-1:0] w_rd_pix;
    logic [1:0]       w_rd_p;
    logic             w_unused;

    assign w_clear    = awvalid && wvalid && (awaddr == STATUS_ADDR) && wdata[0];
    assign w_unused   = ^wdata[31:1];
    assign w_in_range = (save_row < ROW_LIM) && (save_col < COL_LIM);
    // A clear in the same cycle wins over any save; saves in DONE are dropped.
    assign w_save_ok  = save_enable && !w_clear && (r_state != ST_DONE) && w_in_range;
    assign w_drop     = save_enable && !w_clear && ((r_state == ST_DONE) || !w_in_range);
    assign w_wr_pix   = PIX_W'(save_row * COL_LIM + save_col);

    assign w_in_win    = (araddr >= RESULT_BASE) && (araddr < RESULT_END);
    assign w_is_status = (araddr[31:2] == STATUS_ADDR[31:2]);
    assign w_rd_off    = araddr - RESULT_BASE;
    assign w_rd_pix    = PIX_W'(w_rd_off >> 4);
    assign w_rd_p      = w_rd_off[3:2];

    assign rdata        = r_rdata;
    assign result_ready = (r_state == ST_DONE);
    assign save_count   = r_save_count;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a save coinciding with calculation_done is stored and DONE still wins.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (calculation_done) begin
                    w_state_next = ST_DONE;
                end else if (w_save_ok) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (calculation_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_clear) begin
            w_state_next = ST_IDLE;
        end
    end

    // Accepted-pixel counter (saturating) and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_save_count <= '0;
            r_overflow   <= 1'b0;
        end else if (w_clear) begin
            r_save_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_save_ok && (r_save_count != '1)) begin
                r_save_count <= r_save_count + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Pixel buffer write: all four words of a pixel land in one cycle; never reset.
    always_ff @(posedge clk) begin
        if (!rst && w_save_ok) begin
            r_buf[w_wr_pix] <= save_data;
        end
    end

    // Registered read port; reading before the same-cycle buffer write yields old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (arvalid) begin
            if (w_in_win) begin
                r_rdata <= r_buf[w_rd_pix][{w_rd_p, 5'b0} +: 32];
            end else if (w_is_status) begin
                r_rdata <= {r_save_count, 13'b0, r_overflow,
                            (r_state == ST_FILL), (r_state == ST_DONE)};
            end else begin
                r_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_layer2_result_readout.sv
// Self-checking bench for layer2_result_readout: read requests push their
// expected rdata into a scoreboard queue; each clock that carried a request
// pops one entry and compares it against the registered read data.
module tb_layer2_result_readout;

    localparam logic [31:0] RB = 32'h0002_0000;
    localparam logic [31:0] SA = 32'h0001_FFF0;

    logic         clk = 1'b0;
    logic         rst;
    logic         save_enable;
    logic [15:0]  save_row;
    logic [15:0]  save_col;
    logic [127:0] save_data;
    logic         calculation_done;
    logic [31:0]  araddr;
    logic         arvalid;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic [31:0]  wdata;
    logic         wvalid;
    logic [31:0]  rdata;
    logic         result_ready;
    logic [15:0]  save_count;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    logic [31:0]  exp_q[$];
    string        tag_q[$];
    logic [127:0] mdl [784];
    logic [31:0]  last_rd;
    logic [127:0] d_a, d_b, d_c, d_d;

    always #5 clk = ~clk;

    layer2_result_readout #(
        .ROW_NUM     (28),
        .COL_NUM     (28),
        .RESULT_BASE (RB),
        .STATUS_ADDR (SA)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .save_enable      (save_enable),
        .save_row         (save_row),
        .save_col         (save_col),
        .save_data        (save_data),
        .calculation_done (calculation_done),
        .araddr           (araddr),
        .arvalid          (arvalid),
        .awaddr           (awaddr),
        .awvalid          (awvalid),
        .wdata            (wdata),
        .wvalid           (wvalid),
        .rdata            (rdata),
        .result_ready     (result_ready),
        .save_count       (save_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pd(input int r, input int c);
        logic [127:0] v;
        for (int k = 0; k < 8; k++) begin
            v[16*k +: 16] = 16'((r * 28 + c) * 8 + k) ^ 16'hA500;
        end
        return v;
    endfunction

    function automatic logic [31:0] mw(input int r, input int c, input int p);
        logic [127:0] e;
        e = mdl[r * 28 + c];
        return e[32*p +: 32];
    endfunction

    function automatic logic [31:0] st(input logic [15:0] cnt, input logic ovf,
                                       input logic fill, input logic done);
        return {cnt, 13'b0, ovf, fill, done};
    endfunction

    function automatic logic [31:0] pa(input int r, input int c, input int p);
        return RB + 32'((r * 28 + c) * 16 + p * 4);
    endfunction

    // Advance one clock; consume one-shot inputs and score any read issued this cycle.
    task automatic tick();
        logic had_rd;
        logic [31:0] e;
        string t;
        had_rd = arvalid;
        @(posedge clk);
        #1;
        save_enable      = 1'b0;
        calculation_done = 1'b0;
        arvalid          = 1'b0;
        awvalid          = 1'b0;
        wvalid           = 1'b0;
        if (had_rd) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, rdata, e);
            last_rd = rdata;
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        araddr  = addr;
        arvalid = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic sv(input int r, input int c, input logic [127:0] d);
        save_row    = 16'(r);
        save_col    = 16'(c);
        save_data   = d;
        save_enable = 1'b1;
    endtask

    task automatic clr();
        awaddr  = SA;
        wdata   = 32'h1;
        awvalid = 1'b1;
        wvalid  = 1'b1;
    endtask

    initial begin
        rst = 1'b1; save_enable = 1'b0; save_row = '0; save_col = '0; save_data = '0;
        calculation_done = 1'b0; araddr = '0; arvalid = 1'b0; awaddr = '0;
        awvalid = 1'b0; wdata = '0; wvalid = 1'b0; last_rd = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state and status read
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_ready", 32'(result_ready), 32'h0);
        check_eq("rst_count", 32'(save_count), 32'h0);
        rd(SA, 32'h0, "t1_status"); tick();

        // First pixel, ch k = k
        d_a = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        sv(0, 0, d_a); tick(); mdl[0] = d_a;
        check_eq("t2_count", 32'(save_count), 32'd1);
        rd(RB + 32'd4, 32'h0003_0002, "t2_word1"); tick();
        tick();
        check_eq("t2_hold", rdata, last_rd);
        rd(RB + 32'd7, 32'h0003_0002, "t2_lowbits"); tick();
        rd(SA, st(16'd1, 1'b0, 1'b1, 1'b0), "t2_status"); tick();
        clr(); tick();
        rd(SA, 32'h0, "clr_status"); tick();

        // Full map fill and completion
        for (int r = 0; r < 28; r++) begin
            for (int c = 0; c < 28; c++) begin
                sv(r, c, pd(r, c)); tick(); mdl[r * 28 + c] = pd(r, c);
            end
        end
        check_eq("t3_count", 32'(save_count), 32'd784);
        calculation_done = 1'b1; tick();
        check_eq("t3_ready", 32'(result_ready), 32'h1);
        rd(SA, 32'h0310_0001, "t3_status"); tick();
        rd(pa(27, 27, 3), mw(27, 27, 3), "t3_last_w3"); tick();
        rd(pa(13, 5, 0), mw(13, 5, 0), "t3_mid_w0"); tick();
        rd(pa(0, 0, 2), mw(0, 0, 2), "t3_first_w2"); tick();
        rd(RB + 32'd12544, 32'h0, "t3_past_win"); tick();
        rd(RB - 32'd4, 32'h0, "t3_below_win"); tick();
        rd(SA + 32'd3, 32'h0310_0001, "t3_status_lowbits"); tick();
        sv(0, 0, '1); tick();
        check_eq("done_drop_count", 32'(save_count), 32'd784);
        rd(SA, 32'h0310_0005, "done_drop_status"); tick();
        rd(pa(0, 0, 0), mw(0, 0, 0), "done_drop_buf"); tick();

        // Clear from DONE
        clr(); tick();
        check_eq("t6_clr_ready", 32'(result_ready), 32'h0);
        rd(SA, 32'h0, "t6_clr_status"); tick();

        // Out-of-range pixel during FILL
        d_b = pd(2, 3) ^ {4{32'h1234_5678}};
        sv(2, 3, d_b); tick(); mdl[2 * 28 + 3] = d_b;
        sv(28, 0, '1); tick();
        sv(0, 28, '1); tick();
        check_eq("t4_count", 32'(save_count), 32'd1);
        rd(SA, st(16'd1, 1'b1, 1'b1, 1'b0), "t4_status"); tick();
        rd(pa(2, 3, 1), mw(2, 3, 1), "t4_buf"); tick();

        // Clear coinciding with a save: pixel dropped
        clr(); sv(4, 4, '0); tick();
        check_eq("clr_save_count", 32'(save_count), 32'd0);
        rd(SA, 32'h0, "clr_save_status"); tick();
        rd(pa(4, 4, 0), mw(4, 4, 0), "clr_save_buf"); tick();

        // Read-before-write on the same word
        d_a = {4{32'hCAFE_0001}};
        d_b = {4{32'hBEEF_0002}};
        sv(1, 1, d_a); tick(); mdl[29] = d_a;
        sv(1, 1, d_b); rd(pa(1, 1, 0), mw(1, 1, 0), "t5_old"); tick(); mdl[29] = d_b;
        rd(pa(1, 1, 0), mw(1, 1, 0), "t5_new"); tick();

        // Save and completion in the same cycle
        d_c = pd(5, 5) ^ {4{32'h0F0F_F0F0}};
        sv(5, 5, d_c); calculation_done = 1'b1; tick(); mdl[5 * 28 + 5] = d_c;
        check_eq("same_cyc_ready", 32'(result_ready), 32'h1);
        rd(SA, st(16'd3, 1'b0, 1'b0, 1'b1), "same_cyc_status"); tick();
        rd(pa(5, 5, 2), mw(5, 5, 2), "same_cyc_buf"); tick();

        // Second run, then reset mid-FILL
        clr(); tick();
        d_d = pd(6, 6) ^ {4{32'h5A5A_A5A5}};
        sv(6, 6, d_d); tick(); mdl[6 * 28 + 6] = d_d;
        check_eq("run2_count", 32'(save_count), 32'd1);
        rd(SA, st(16'd1, 1'b0, 1'b1, 1'b0), "run2_status"); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("midrst_rdata", rdata, 32'h0);
        check_eq("midrst_count", 32'(save_count), 32'h0);
        check_eq("midrst_ready", 32'(result_ready), 32'h0);
        rd(SA, 32'h0, "midrst_status"); tick();
        rd(pa(6, 6, 3), mw(6, 6, 3), "midrst_buf_kept"); tick();

        // calculation_done in IDLE with no saves
        calculation_done = 1'b1; tick();
        check_eq("idle_done_ready", 32'(result_ready), 32'h1);
        rd(SA, st(16'd0, 1'b0, 1'b0, 1'b1), "idle_done_status"); tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
